// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: sequences multi-cycle MULT/DIV ops,
// owns the HI/LO registers and raises the pipeline stall for MD hazards.
module mdu_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_RAW = $clog2(MAX_CYC + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 4) ? 4 : CNT_RAW;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             busy_q, busy_d;

  logic               unsigned_op;
  logic signed [63:0] mul_sa, mul_sb, mul_s;
  logic [63:0]        mul_u, mul_res;
  logic               div_ok, div_ovf;
  logic [31:0]        b_safe, div_quo, div_rem;
  logic               last_cycle, can_issue;

  // Result datapath from the latched operands; only sampled on the commit edge.
  always_comb begin
    unsigned_op = (op_q == OP_MULTU) || (op_q == OP_DIVU);
    mul_sa      = {{32{a_q[31]}}, a_q};
    mul_sb      = {{32{b_q[31]}}, b_q};
    mul_s       = mul_sa * mul_sb;
    mul_u       = {32'd0, a_q} * {32'd0, b_q};
    mul_res     = unsigned_op ? mul_u : 64'(mul_s);
    div_ok      = (b_q != 32'd0);
    div_ovf     = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    b_safe      = div_ok ? b_q : 32'd1;
    if (unsigned_op) begin
      div_quo = a_q / b_safe;
      div_rem = a_q % b_safe;
    end else if (div_ovf) begin
      // Most-negative / -1 wraps back to itself with zero remainder.
      div_quo = 32'h8000_0000;
      div_rem = 32'd0;
    end else begin
      div_quo = 32'($signed(a_q) / $signed(b_safe));
      div_rem = 32'($signed(a_q) % $signed(b_safe));
    end
  end

  // Next-state: countdown/commit, then issue (idle or back-to-back on the commit edge).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    last_cycle = (state_q != S_IDLE) && (cnt_q == CNT_W'(1));
    can_issue  = (state_q == S_IDLE) || last_cycle;

    if (state_q != S_IDLE) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (last_cycle) begin
        state_d = S_IDLE;
        if (state_q == S_MUL) begin
          hi_d = mul_res[63:32];
          lo_d = mul_res[31:0];
        end else if (div_ok) begin
          hi_d = div_rem;
          lo_d = div_quo;
        end
      end
    end

    if (start && can_issue) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          a_d     = src_a;
          b_d     = src_b;
          op_d    = op;
          cnt_d   = CNT_W'(MUL_CYCLES);
          state_d = S_MUL;
        end
        OP_DIV, OP_DIVU: begin
          a_d     = src_a;
          b_d     = src_b;
          op_d    = op;
          cnt_d   = CNT_W'(DIV_CYCLES);
          state_d = S_DIV;
        end
        OP_MTHI: hi_d = src_a;
        OP_MTLO: lo_d = src_a;
        default: ;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and HI/LO registers; async reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  // Stall D while an MD op is busy or about to issue a multi-cycle op.
  assign md_stall = d_uses_md & (busy_q | (start & (op <= OP_DIVU)));

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with hand-computed expected values.
`timescale 1ns/1ps
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_uses_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_fail;

  mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .d_uses_md(d_uses_md),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one edge, then drop it.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    start     = 1'b1;
    op        = 3'd0;
    src_a     = 32'd0;
    src_b     = 32'd0;
    d_uses_md = 1'b1;

    // Reset state, stall during reset follows start/op with busy=0
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall_issue", 32'(md_stall), 32'd1);
    op = 3'd4;
    #1;
    chk("rst_stall_mthi", 32'(md_stall), 32'd0);
    start = 1'b0;
    d_uses_md = 1'b0;
    tick();
    #4 reset = 1'b0;
    tick();

    // MULT -2 * 3
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    for (int k = 0; k < 5; k++) begin
      chk("mult_busy", 32'(busy), 32'd1);
      chk("mult_hold_lo", lo, 32'd0);
      tick();
    end
    chk("mult_done_busy", 32'(busy), 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // MULTU 0xFFFFFFFF squared
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 0; k < 4; k++) tick();
    chk("multu_busy4", 32'(busy), 32'd1);
    chk("multu_hold_hi", hi, 32'hFFFF_FFFF);
    tick();
    chk("multu_busy", 32'(busy), 32'd0);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    // MTHI / MTLO: no busy, no stall
    start = 1'b1; op = 3'd4; src_a = 32'hABCD_0000; d_uses_md = 1'b1;
    #1;
    chk("mthi_stall", 32'(md_stall), 32'd0);
    tick();
    start = 1'b0;
    chk("mthi_hi", hi, 32'hABCD_0000);
    chk("mthi_lo_keep", lo, 32'h0000_0001);
    chk("mthi_busy", 32'(busy), 32'd0);
    issue(3'd5, 32'h1234_5678, 32'd0);
    chk("mtlo_lo", lo, 32'h1234_5678);
    chk("mtlo_hi_keep", hi, 32'hABCD_0000);

    // DIV -7 / 2 with ignored mid-op MULT and stall checks
    d_uses_md = 1'b0;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_stall_nouse", 32'(md_stall), 32'd0);
    d_uses_md = 1'b1;
    #1;
    chk("div_stall_busy", 32'(md_stall), 32'd1);
    for (int k = 0; k < 3; k++) tick();
    issue(3'd0, 32'd5, 32'd5);
    d_uses_md = 1'b0;
    #1;
    chk("div_stall_off", 32'(md_stall), 32'd0);
    chk("div_ignore_lo", lo, 32'h1234_5678);
    for (int k = 0; k < 5; k++) tick();
    chk("div_busy9", 32'(busy), 32'd1);
    tick();
    chk("div_busy10", 32'(busy), 32'd0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // Divide by zero keeps prior HI/LO
    issue(3'd4, 32'h0000_0011, 32'd0);
    issue(3'd5, 32'h0000_0022, 32'd0);
    issue(3'd2, 32'd100, 32'd0);
    for (int k = 0; k < 9; k++) tick();
    chk("dz_busy9", 32'(busy), 32'd1);
    tick();
    chk("dz_busy10", 32'(busy), 32'd0);
    chk("dz_hi", hi, 32'h0000_0011);
    chk("dz_lo", lo, 32'h0000_0022);

    // Signed overflow case
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int k = 0; k < 10; k++) tick();
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0000_0000);

    // DIVU 0xFFFFFFFF / 16
    issue(3'd3, 32'hFFFF_FFFF, 32'h0000_0010);
    for (int k = 0; k < 10; k++) tick();
    chk("divu_lo", lo, 32'h0FFF_FFFF);
    chk("divu_hi", hi, 32'h0000_000F);

    // Back-to-back MULT at the commit edge
    issue(3'd0, 32'd7, 32'd6);
    for (int k = 0; k < 4; k++) tick();
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_first_lo", lo, 32'h0000_002A);
    chk("b2b_first_hi", hi, 32'h0000_0000);
    for (int k = 0; k < 4; k++) tick();
    chk("b2b_busy4", 32'(busy), 32'd1);
    tick();
    chk("b2b_done", 32'(busy), 32'd0);
    chk("b2b_lo", lo, 32'h0000_0001);
    chk("b2b_hi", hi, 32'h0000_0000);

    // Reserved op ignored
    start = 1'b1; op = 3'd6; src_a = 32'hDEAD_BEEF; d_uses_md = 1'b1;
    #1;
    chk("rsv_stall", 32'(md_stall), 32'd0);
    tick();
    start = 1'b0;
    chk("rsv_busy", 32'(busy), 32'd0);
    chk("rsv_hi", hi, 32'h0000_0000);
    chk("rsv_lo", lo, 32'h0000_0001);

    // Async reset during cycle 3 of a DIV
    d_uses_md = 1'b0;
    issue(3'd4, 32'h0000_0055, 32'd0);
    issue(3'd2, 32'd100, 32'd7);
    tick();
    tick();
    #3 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    #2 reset = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk("arst_nocommit_busy", 32'(busy), 32'd0);
    chk("arst_nocommit_lo", lo, 32'd0);
    chk("arst_nocommit_hi", hi, 32'd0);

    // First start after reset is accepted
    issue(3'd5, 32'h0000_0077, 32'd0);
    chk("post_rst_mtlo", lo, 32'h0000_0077);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
